display_scan_scheduler: RTL and testbench
=========================================

// Module: display_scan_scheduler
// PURPOSE
//  Sequences the 8-digit common-anode 7-segment display.
//  Each frame visits only the enabled digits, in ascending order from digit 0 to digit 7.
//  Each visit is a fixed-length slot: guard tick, then PWM brightness on-time, then off-time.
//  Drives active-low anodes and the digit-mux select (seg_sel) that picks the address/data nibble upstream.
// PARAMETERS
//  SLOT_TICKS  4  clk_480Hz ticks per digit slot; legal 2..16
// PORTS
//  clk_480Hz    in   1  scan clock; all state and outputs update on posedge
//  reset        in   1  asynchronous, active-high
//  digit_en     in   8  per-digit enable, bit i = digit i; 0 = skipped, takes no slot time
//  brightness   in   3  on-ticks per slot, clamped to SLOT_TICKS-1
//  blank_all    in   1  1 = force all anodes off; FSM keeps running
//  an           out  8  anodes, active low, an[i] drives digit i
//  seg_sel      out  3  index of the digit being scanned (nibble mux select)
//  frame_start  out  1  1-tick pulse on the first slot of each frame
//  active       out  1  1 whenever FSM is not in IDLE
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, cur=0, tick_cnt=0, an=8'hFF, seg_sel=0, frame_start=0, active=0.
//  - All outputs are registered and decoded from next state, so each output is valid in the same tick the FSM occupies that state.
//  - IDLE: an=FF.
//      If digit_en!=0 -> GUARD at lowest set bit, with frame_start=1.
//      Otherwise stay in IDLE.
//  - GUARD (1 tick, tick_cnt=0): an=FF; seg_sel=cur.
//      Latch on_len = min(brightness, SLOT_TICKS-1).
//      Next state is ON if on_len>0, else OFF.
//  - ON: an=~(8'b1<<cur); lasts on_len ticks. Then OFF, or slot end if tick_cnt reaches SLOT_TICKS-1.
//  - OFF: an=FF until tick_cnt=SLOT_TICKS-1.
//  - Slot length is always SLOT_TICKS = 1 guard + on_len + remaining off ticks.
//  - Slot end: pick the next set bit of digit_en above cur, searching upward.
//      If none above, wrap to the lowest set bit and pulse frame_start with that GUARD.
//      If digit_en==0 -> IDLE, an=FF, active=0.
//      A single enabled digit repeats every slot, with frame_start on each slot.
//  - digit_en and brightness are sampled only at slot start.
//      Mid-slot changes never shorten or alter the current slot.
//      A digit disabled mid-slot completes its slot.
//  - blank_all is sampled every tick; while it is high, an=FF in the following tick.
//      seg_sel, tick_cnt, frame_start and state progress are unaffected.
//  - Only one anode is ever low at once.
//  - seg_sel changes only in a GUARD tick, where an=FF, giving anti-ghosting.
//  - Illegal state encodings recover to IDLE on the next tick.
// TESTING
//  1 SLOT_TICKS=4, digit_en=FF, brightness=7, release reset:
//      an per slot = FF,FE,FE,FE then FF,FD,FD,FD, and so on up to digit 7.
//      seg_sel 0..7; frame_start every 32 ticks.
//  2 brightness=1, digit_en=FF: each slot an = FF, ~bit, FF, FF; frame period still 32 ticks.
//  3 brightness=0: an stays FF for the whole frame; seg_sel still steps 0..7; frame_start every 32.
//  4 digit_en=8'b1000_0001, brightness=3: slots alternate seg_sel=0 and 7 with frame_start every 8 ticks.
//      Clear digit_en during digit-7 ON: slot completes (an=7F until slot end), then IDLE, an=FF, active=0.
//  5 digit_en=FF, brightness=3: assert blank_all for 2 ticks during ON of digit 2.
//      an=FF for exactly those 2 following ticks; next GUARD (seg_sel=3) occurs at the unchanged tick.
//  6 Assert reset mid-ON of digit 5: an=FF, seg_sel=0, active=0 immediately, without waiting for a clock edge.
//      After release with digit_en=FF, the first GUARD is seg_sel=0 with frame_start=1.

Source files
------------

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler
//   Scan sequencer for an 8-digit common-anode 7-segment display. Each frame
//   visits the enabled digits in ascending order. Every visit is a fixed slot
//   of SLOT_TICKS ticks: one guard tick, then the PWM on-time, then off-time.
//
//   state | meaning
//   IDLE  | no digit enabled, all anodes off
//   GUARD | first slot tick, anodes off, seg_sel moves to the new digit
//   ON    | current digit's anode driven low for on_len ticks
//   OFF   | anodes off for the rest of the slot
//
// Ports
//   clk_480Hz      scan clock, everything updates on posedge
//   reset          asynchronous, active-high
//   digit_en_i     per-digit enable, bit i = digit i (sampled at slot start)
//   brightness_i   on-ticks per slot, clamped to SLOT_TICKS-1 (sampled in GUARD)
//   blank_all_i    forces all anodes off on the following tick
//   an_o           anodes, active low, an_o[i] drives digit i
//   seg_sel_o      index of the digit being scanned
//   frame_start_o  one-tick pulse on the GUARD of the first slot of a frame
//   active_o       high whenever the sequencer is not in IDLE
module display_scan_scheduler #(
   parameter int SLOT_TICKS = 4
) (
   input  logic       clk_480Hz,
   input  logic       reset,
   input  logic [7:0] digit_en_i,
   input  logic [2:0] brightness_i,
   input  logic       blank_all_i,
   output logic [7:0] an_o,
   output logic [2:0] seg_sel_o,
   output logic       frame_start_o,
   output logic       active_o
);

   localparam logic [3:0] LAST_TICK = 4'(SLOT_TICKS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GUARD = 2'd1,
      S_ON    = 2'd2,
      S_OFF   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cur_q, cur_d;
   logic [3:0] tick_q, tick_d;
   logic [3:0] on_len_q, on_len_d;
   logic [7:0] an_q, an_d;
   logic       fs_q, fs_d;
   logic       active_q, active_d;

   logic [2:0] lowest_en;
   logic [3:0] above_en;   // {found, index} of next enabled digit above cur_q
   logic [3:0] bright_clamped;
   logic       slot_end;

   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

   function automatic logic [3:0] next_above(input logic [7:0] v, input logic [2:0] c);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i] && (i > int'(c))) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

   assign lowest_en      = lowest_set(digit_en_i);
   assign above_en       = next_above(digit_en_i, cur_q);
   assign bright_clamped = ({1'b0, brightness_i} > LAST_TICK) ? LAST_TICK : {1'b0, brightness_i};

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      tick_d   = tick_q;
      on_len_d = on_len_q;
      fs_d     = 1'b0;
      slot_end = 1'b0;

      case (state_q)
         S_IDLE: begin
            tick_d = 4'd0;
            if (digit_en_i != 8'h00) begin
               state_d = S_GUARD;
               cur_d   = lowest_en;
               fs_d    = 1'b1;
            end
         end
         S_GUARD: begin
            on_len_d = bright_clamped;
            tick_d   = 4'd1;
            state_d  = (bright_clamped != 4'd0) ? S_ON : S_OFF;
         end
         S_ON: begin
            tick_d = tick_q + 4'd1;
            if (tick_q == LAST_TICK) begin
               slot_end = 1'b1;
            end else if (tick_q == on_len_q) begin
               state_d = S_OFF;
            end
         end
         S_OFF: begin
            tick_d = tick_q + 4'd1;
            if (tick_q == LAST_TICK) slot_end = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            tick_d  = 4'd0;
         end
      endcase

      // cur_q is left alone on the way to IDLE so seg_sel only moves in GUARD
      if (slot_end) begin
         tick_d = 4'd0;
         if (digit_en_i == 8'h00) begin
            state_d = S_IDLE;
         end else if (above_en[3]) begin
            state_d = S_GUARD;
            cur_d   = above_en[2:0];
         end else begin
            state_d = S_GUARD;
            cur_d   = lowest_en;
            fs_d    = 1'b1;
         end
      end

      // outputs decoded from the next state so they line up with it
      an_d     = ((state_d == S_ON) && !blank_all_i) ? ~(8'h01 << cur_d) : 8'hFF;
      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_480Hz or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cur_q    <= 3'd0;
         tick_q   <= 4'd0;
         on_len_q <= 4'd0;
         an_q     <= 8'hFF;
         fs_q     <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         tick_q   <= tick_d;
         on_len_q <= on_len_d;
         an_q     <= an_d;
         fs_q     <= fs_d;
         active_q <= active_d;
      end
   end

   assign an_o          = an_q;
   assign seg_sel_o     = cur_q;
   assign frame_start_o = fs_q;
   assign active_o      = active_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
module tb_display_scan_scheduler;

   logic       clk_480Hz = 1'b0;
   logic       reset;
   logic [7:0] digit_en;
   logic [2:0] brightness;
   logic       blank_all;
   logic [7:0] an;
   logic [2:0] seg_sel;
   logic       frame_start;
   logic       active;

   display_scan_scheduler #(.SLOT_TICKS(4)) dut (
      .clk_480Hz    (clk_480Hz),
      .reset        (reset),
      .digit_en_i   (digit_en),
      .brightness_i (brightness),
      .blank_all_i  (blank_all),
      .an_o         (an),
      .seg_sel_o    (seg_sel),
      .frame_start_o(frame_start),
      .active_o     (active)
   );

   always #5 clk_480Hz = ~clk_480Hz;

   int cyc_cnt = 0;
   always @(posedge clk_480Hz) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      int         cyc;
      logic [7:0] an;
      logic [2:0] sel;
      logic       fs;
      logic       act;
      logic       sel_care;
      string      nm;
   } exp_t;

   exp_t sb_q[$];      // expectations tagged with the tick they belong to
   exp_t async_q[$];   // expectations to check immediately (async reset)
   event async_chk;
   logic done = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic cmp(string nm, int cyc, logic [7:0] got, logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%02h exp=%02h", nm, cyc, got, exp);
      end
   endtask

   task automatic cmp_entry(exp_t e);
      cmp({e.nm, "_an"}, e.cyc, an, e.an);
      if (e.sel_care) cmp({e.nm, "_sel"}, e.cyc, {5'd0, seg_sel}, {5'd0, e.sel});
      cmp({e.nm, "_fs"}, e.cyc, {7'd0, frame_start}, {7'd0, e.fs});
      cmp({e.nm, "_act"}, e.cyc, {7'd0, active}, {7'd0, e.act});
   endtask

   // monitor: the only process that compares and counts
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_480Hz or async_chk);
         while (async_q.size() > 0) begin
            e = async_q.pop_front();
            cmp_entry(e);
         end
         while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            e = sb_q.pop_front();
            if (e.cyc < cyc_cnt) begin
               n_chk++;
               n_fail++;
               $display("FAIL %s_missed cyc=%0d got=none exp=checked", e.nm, e.cyc);
            end else begin
               cmp_entry(e);
            end
         end
         if (reset === 1'b0) begin
            n_chk++;
            if ($countones(~an) > 1) begin
               n_fail++;
               $display("FAIL one_anode cyc=%0d got=%02h exp=at_most_one_low", cyc_cnt, an);
            end
         end
         if (done) begin
            n_chk++;
            if (sb_q.size() != 0) begin
               n_fail++;
               $display("FAIL drain got=%0d_left exp=0_left", sb_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic push(int c, logic [7:0] a, logic [2:0] s, logic fs, logic act,
                       logic sc, string nm);
      exp_t e;
      e.cyc = c; e.an = a; e.sel = s; e.fs = fs; e.act = act; e.sel_care = sc; e.nm = nm;
      sb_q.push_back(e);
   endtask

   task automatic push_async(logic [7:0] a, logic [2:0] s, logic fs, logic act, string nm);
      exp_t e;
      e.cyc = -1; e.an = a; e.sel = s; e.fs = fs; e.act = act; e.sel_care = 1'b1; e.nm = nm;
      async_q.push_back(e);
   endtask

   // one slot of a 4-tick schedule: guard, on_len ON ticks, then OFF;
   // blank_m marks slot ticks whose anodes are forced off
   task automatic push_slot(int c, int d, int on_len, logic fs, logic [3:0] blank_m,
                            int nt, string nm);
      for (int k = 0; k < nt; k++) begin
         logic [7:0] a;
         logic [7:0] one;
         one = 8'h01 << d;
         a   = (k >= 1 && k <= on_len && !blank_m[k]) ? ~one : 8'hFF;
         push(c + k, a, 3'(d), (k == 0) ? fs : 1'b0, 1'b1, 1'b1, nm);
      end
   endtask

   task automatic wait_until(int c);
      while (cyc_cnt < c) @(negedge clk_480Hz);
   endtask

   initial begin
      int b1, b2, b3, b4, b5, b6;
      reset      = 1'b1;
      digit_en   = 8'hFF;
      brightness = 3'd7;
      blank_all  = 1'b0;
      repeat (3) @(negedge clk_480Hz);
      #2;
      push_async(8'hFF, 3'd0, 1'b0, 1'b0, "reset_state");
      ->async_chk;

      // 1: all digits, brightness clamped to 3, two frames
      @(negedge clk_480Hz);
      reset = 1'b0;
      b1 = cyc_cnt + 1;
      for (int f = 0; f < 2; f++)
         for (int d = 0; d < 8; d++)
            push_slot(b1 + f * 32 + d * 4, d, 3, d == 0, 4'b0000, 4, "t1");

      // 2: brightness 1
      wait_until(b1 + 63);
      brightness = 3'd1;
      b2 = b1 + 64;
      for (int d = 0; d < 8; d++) push_slot(b2 + d * 4, d, 1, d == 0, 4'b0000, 4, "t2");

      // 3: brightness 0
      wait_until(b2 + 31);
      brightness = 3'd0;
      b3 = b2 + 32;
      for (int d = 0; d < 8; d++) push_slot(b3 + d * 4, d, 0, d == 0, 4'b0000, 4, "t3");

      // 4: digits 0 and 7, then disable during digit 7 ON
      wait_until(b3 + 31);
      digit_en   = 8'b1000_0001;
      brightness = 3'd3;
      b4 = b3 + 32;
      push_slot(b4,      0, 3, 1'b1, 4'b0000, 4, "t4");
      push_slot(b4 + 4,  7, 3, 1'b0, 4'b0000, 4, "t4");
      push_slot(b4 + 8,  0, 3, 1'b1, 4'b0000, 4, "t4");
      push_slot(b4 + 12, 7, 3, 1'b0, 4'b0000, 4, "t4_dis");
      for (int k = 16; k <= 18; k++) push(b4 + k, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0, "t4_idle");
      wait_until(b4 + 13);
      digit_en = 8'h00;

      // 5: restart from IDLE, blank two ticks during digit 2 ON
      wait_until(b4 + 18);
      digit_en = 8'hFF;
      b5 = b4 + 19;
      for (int d = 0; d < 5; d++)
         push_slot(b5 + d * 4, d, 3, d == 0, (d == 2) ? 4'b1100 : 4'b0000, 4, "t5");
      push_slot(b5 + 20, 5, 3, 1'b0, 4'b0000, 3, "t5");
      wait_until(b5 + 9);
      blank_all = 1'b1;
      wait_until(b5 + 11);
      blank_all = 1'b0;

      // 6: async reset during digit 5 ON, then restart
      wait_until(b5 + 22);
      #2;
      reset = 1'b1;
      #1;
      push_async(8'hFF, 3'd0, 1'b0, 1'b0, "t6_async_reset");
      ->async_chk;
      repeat (2) @(negedge clk_480Hz);
      reset = 1'b0;
      b6 = cyc_cnt + 1;
      for (int d = 0; d < 8; d++) push_slot(b6 + d * 4, d, 3, d == 0, 4'b0000, 4, "t6");
      push_slot(b6 + 32, 0, 3, 1'b1, 4'b0000, 1, "t6_wrap");

      wait_until(b6 + 34);
      #2;
      done = 1'b1;
      ->async_chk;
   end

endmodule
